dm_latency_ctrl: RTL

// Parametrised data memory for the pipelined CPU's MEM stage, replacing the single-cycle word RAM.
// - Sub-word stores (sb/sh/sw) use internal byte-lane merging.
// - Sign- or zero-extends sub-word loads (lb/lbu/lh/lhu/lw).
// - Flags misaligned or out-of-range accesses.
// - Models a configurable access latency through a req/ack handshake; the pipeline stalls on busy.

---
 rtl/dm_latency_ctrl.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dm_latency_ctrl.sv
// -----------------------------------------------------------------------------
// dm_latency_ctrl
//
// Data memory for the MEM stage of the pipelined CPU. Accepts one access per
// req/ack handshake, completes it LATENCY cycles after acceptance, merges
// sub-word stores into the addressed word, extends sub-word loads and flags
// misaligned / out-of-range accesses instead of touching memory.
//
// Parameters
//   ADDR_W   word-address bits, depth = 2**ADDR_W words of 32 bits
//   LATENCY  cycles from acceptance to ack (1..15)
//   LOG_EN   non-zero: print one line per committed store
//
// Ports
//   clk       in   1   clock, rising edge
//   reset     in   1   synchronous, active-high
//   req       in   1   access request, sampled only while idle
//   we        in   1   1 = store, 0 = load
//   addr      in   32  byte address
//   size      in   2   00 byte, 01 half, 10 word, 11 illegal
//   sign_ext  in   1   loads: 1 = sign-extend, 0 = zero-extend
//   wdata     in   32  store data, right-justified
//   pc        in   32  PC of the requesting instruction (log only)
//   busy      out  1   high from the cycle after acceptance through the ack cycle
//   ack       out  1   one-cycle completion pulse
//   rdata     out  32  extended load data, held until the next ack
//   exc_adel  out  1   load fault, only with ack
//   exc_ades  out  1   store fault, only with ack
// -----------------------------------------------------------------------------
module dm_latency_ctrl #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned LOG_EN  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        busy,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        exc_adel,
  output logic        exc_ades
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [1:0]        size_q;
  logic              sext_q;
  logic [31:0]       wdata_q;
  logic [31:0]       pc_q;
  logic              busy_q;
  logic              ack_q;
  logic [31:0]       rdata_q;
  logic              adel_q;
  logic              ades_q;

  // The word array itself has no reset so it can map onto block RAM. A
  // per-word written flag, cleared by reset, makes every word read as zero
  // until it is stored to again after reset.
  logic [31:0]       mem_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [31:0]       rd_word_q;
  logic              vld_hit_q;

  logic [ADDR_W-1:0] idx_in;
  logic [ADDR_W-1:0] idx_q;
  logic              accept;
  logic              commit;
  logic              fault;
  logic              mem_we;
  logic [3:0]        be;
  logic [31:0]       wdata_rep;
  logic [31:0]       old_word;
  logic [31:0]       merged_word;
  logic [31:0]       shifted;
  logic [31:0]       load_data;

  assign idx_in = addr[ADDR_W+1:2];
  assign idx_q  = addr_q[ADDR_W+1:2];
  assign accept = (state_q == S_IDLE) && req;
  assign commit = (state_q == S_WAIT) && (cnt_q == 4'd0);

  // Fault decision uses only the fields latched at acceptance.
  assign fault = (size_q == 2'b11)
              || ((size_q == 2'b01) && addr_q[0])
              || ((size_q == 2'b10) && (addr_q[1:0] != 2'b00))
              || ((addr_q >> (ADDR_W + 2)) != 32'd0);

  // A reset at the commit edge must abort the write.
  assign mem_we = commit && we_q && !fault && !reset;

  // The old word was read at acceptance; it is stable by the commit edge
  // because only one access is ever in flight.
  assign old_word = vld_hit_q ? rd_word_q : 32'h0;

  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata_q;
    case (size_q)
      2'b00: begin
        be        = 4'b0001 << addr_q[1:0];
        wdata_rep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be        = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        be        = 4'b1111;
        wdata_rep = wdata_q;
      end
      default: begin
        be        = 4'b0000;
        wdata_rep = wdata_q;
      end
    endcase
  end

  // Byte-lane merge: enabled lanes take the replicated store data, the rest
  // keep the old word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign merged_word[8*gi +: 8] = be[gi] ? wdata_rep[8*gi +: 8] : old_word[8*gi +: 8];
  end

  assign shifted = old_word >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_data = old_word;
    case (size_q)
      2'b00:   load_data = {{24{sext_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = {{16{sext_q & shifted[15]}}, shifted[15:0]};
      default: load_data = old_word;
    endcase
  end

  // Block-RAM style port: registered read at acceptance, write at commit.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx_q] <= merged_word;
    end
    if (accept) begin
      rd_word_q <= mem_q[idx_in];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      size_q    <= 2'b00;
      sext_q    <= 1'b0;
      wdata_q   <= 32'h0;
      pc_q      <= 32'h0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= 32'h0;
      adel_q    <= 1'b0;
      ades_q    <= 1'b0;
      vld_q     <= '0;
      vld_hit_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ack_q  <= 1'b0;
          adel_q <= 1'b0;
          ades_q <= 1'b0;
          if (req) begin
            we_q      <= we;
            addr_q    <= addr;
            size_q    <= size;
            sext_q    <= sign_ext;
            wdata_q   <= wdata;
            pc_q      <= pc;
            vld_hit_q <= vld_q[idx_in];
            cnt_q     <= 4'(LATENCY - 1);
            busy_q    <= 1'b1;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= S_DONE;
            ack_q   <= 1'b1;
            if (fault) begin
              rdata_q <= 32'h0;
              adel_q  <= !we_q;
              ades_q  <= we_q;
            end else if (!we_q) begin
              rdata_q <= load_data;
            end else begin
              vld_q[idx_q] <= 1'b1;
            end
          end
        end
        S_DONE: begin
          // req is deliberately ignored here; the next access is taken in IDLE.
          ack_q   <= 1'b0;
          adel_q  <= 1'b0;
          ades_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ack_q   <= 1'b0;
          adel_q  <= 1'b0;
          ades_q  <= 1'b0;
        end
      endcase
    end
  end

  // Simulation-visible store trace; synthesis ignores the system task.
  if (LOG_EN != 0) begin : g_log
    always_ff @(posedge clk) begin
      if (mem_we) begin
        $write("%d@%h: *%h <= %h\n", $time, pc_q, {addr_q[31:2], 2'b00}, merged_word);
      end
    end
  end

  assign busy     = busy_q;
  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign exc_adel = adel_q;
  assign exc_ades = ades_q;

endmodule
